mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Two-port round-robin arbiter in front of the byte-wide PSRAM memory block (go/done handshake).
//   Lets two requesters, e.g. CPU and display fetch, share one memory controller. Sequences each access
//   end to end: holds go until the controller accepts it, then waits for done. A timeout flags a hung controller.
// PARAMETERS
//   ADDR_W       32  address width, passed through unchanged
//   DATA_W       8   data width
//   TIMEOUT      32  max cycles in WAIT before forced completion (>=2)
//   P0_PRIORITY  0   0 = round-robin; 1 = fixed priority, port 0 always wins
// PORTS
//   clk          in   1       single clock; all logic on posedge
//   rst_n        in   1       asynchronous, active-low reset
//   p0_req       in   1       port 0 request; held high until p0_ack
//   p0_we        in   1       port 0 1=write, 0=read
//   p0_addr      in   ADDR_W  port 0 address
//   p0_wdata     in   DATA_W  port 0 write data
//   p0_ack       out  1       one-cycle completion pulse
//   p0_rdata     out  DATA_W  port 0 read data, valid from p0_ack onward
//   p1_*         -    -       identical set for port 1
//   mem_go       out  1       to memory go
//   mem_we       out  1       to memory write_enable
//   mem_addr     out  ADDR_W  to memory addr
//   mem_wdata    out  DATA_W  to memory data_i
//   mem_rdata    in   DATA_W  from memory data_o
//   mem_done     in   1       from memory done
//   busy         out  1       high in any state other than IDLE
//   timeout_err  out  1       sticky; set on any timeout, cleared only by reset
// BEHAVIOUR
//   Reset: state=IDLE. mem_go, mem_we, p*_ack, timeout_err = 0. mem_addr, mem_wdata, p*_rdata = 0.
//     last_grant=1, so port 0 wins the first tie. Reset mid-access abandons it, with no ack.
//   All outputs are registered. Requester fields are latched at grant; later changes are ignored until ack.
//   FSM IDLE -> ISSUE -> WAIT -> ACK -> IDLE:
//   IDLE: if any req, pick grant and latch addr/we/wdata onto mem_*. Set mem_go=1 and move to ISSUE.
//     Grant with both req: ~last_grant (round-robin), or port 0 if P0_PRIORITY=1. With one req: that port.
//   ISSUE: hold mem_go=1 until mem_done==0 is sampled, then mem_go=0 and move to WAIT.
//     No timeout here: the controller's startup configuration can ignore go for ~40 cycles.
//     A high or X mem_done before the first access is treated as "not accepted".
//   WAIT: timer increments each cycle, starting at 0 on entry.
//     mem_done==1: on reads, load granted p*_rdata <= mem_rdata; then ACK.
//     timer==TIMEOUT-1 with mem_done still 0: timeout_err<=1; on reads, granted rdata <= 0; then ACK.
//   ACK: granted p*_ack=1 for exactly this cycle, last_grant<=grant, then IDLE.
//     req is not sampled in ACK, so a req still high on the ack cycle cannot re-grant.
//     IDLE can grant the next cycle, so back-to-back accesses have one idle cycle between ACK and ISSUE.
//   Writes leave p*_rdata unchanged. The ungranted port's outputs never change.
//   Latency from grant: 1 (IDLE) + ISSUE cycles + WAIT cycles + 1 (ACK).
//     With a controller WAIT_TIME of 10 that is ~14 cycles, req to ack.
//   Both ports stay high continuously: grants alternate 0,1,0,1 (round-robin), so neither port starves.
//   A new req arriving while busy waits in order; no request is dropped.
// TESTING
//   1 Reset: assert rst_n=0 mid-WAIT -> all outputs 0 immediately; after release, no spurious ack.
//   2 Single read: p0 read addr 0x10, model returns 0xA5 after 12 cycles -> one p0_ack, p0_rdata=0xA5.
//   3 Single write: p1 write 0x3C to 0x20 -> mem_we=1, mem_addr=0x20, mem_wdata=0x3C, one p1_ack.
//     Afterwards p1_rdata is unchanged.
//   4 Contention: p0 and p1 both req continuously for 4 accesses -> grant order 0,1,0,1.
//     With P0_PRIORITY=1 -> all four grants go to port 0.
//   5 Startup: model ignores go for 40 cycles -> mem_go held high throughout, then access completes.
//     timeout_err stays 0.
//   6 Hang: model never raises done -> ack exactly TIMEOUT cycles after WAIT entry, rdata=0.
//     timeout_err=1 and stays set; the next access still completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the PSRAM go/done controller: picks a requester, runs one access
// end to end, and returns a one-cycle ack. A WAIT-phase timeout forces completion and sets a sticky flag.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT     = 32,
    parameter int P0_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_go,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              busy,
    output logic              timeout_err,
    output logic [1:0]        dbg_state_o
);
    // Handshakes: a requester holds req (and its fields) until its one-cycle ack; the controller
    // accepts go when it drives done low, and finishes the access when it drives done high again.
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, ACK = 2'd3} state_t;

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    state_t            state_q;
    logic              grant_q;
    logic              last_grant_q;
    logic [TW-1:0]     timer_q;
    logic              mem_go_q, mem_we_q, timeout_err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, p0_rdata_q, p1_rdata_q;
    logic              p0_ack_q, p1_ack_q;
    logic              pick_p1;

    always_comb begin
        if (p0_req && p1_req) begin
            pick_p1 = (P0_PRIORITY != 0) ? 1'b0 : ~last_grant_q;
        end else begin
            pick_p1 = p1_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            timer_q       <= '0;
            mem_go_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            p0_rdata_q    <= '0;
            p1_rdata_q    <= '0;
            p0_ack_q      <= 1'b0;
            p1_ack_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        grant_q     <= pick_p1;
                        mem_we_q    <= pick_p1 ? p1_we    : p0_we;
                        mem_addr_q  <= pick_p1 ? p1_addr  : p0_addr;
                        mem_wdata_q <= pick_p1 ? p1_wdata : p0_wdata;
                        mem_go_q    <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Only a definite low counts as accepted; high or unknown keeps go asserted.
                    if (mem_done == 1'b0) begin
                        mem_go_q <= 1'b0;
                        timer_q  <= '0;
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_done == 1'b1) begin
                        if (!mem_we_q) begin
                            if (grant_q) p1_rdata_q <= mem_rdata;
                            else         p0_rdata_q <= mem_rdata;
                        end
                        if (grant_q) p1_ack_q <= 1'b1;
                        else         p0_ack_q <= 1'b1;
                        state_q <= ACK;
                    end else if (timer_q == TMAX) begin
                        timeout_err_q <= 1'b1;
                        if (!mem_we_q) begin
                            if (grant_q) p1_rdata_q <= '0;
                            else         p0_rdata_q <= '0;
                        end
                        if (grant_q) p1_ack_q <= 1'b1;
                        else         p0_ack_q <= 1'b1;
                        state_q <= ACK;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ACK: begin
                    p0_ack_q     <= 1'b0;
                    p1_ack_q     <= 1'b0;
                    last_grant_q <= grant_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign p0_ack      = p0_ack_q;
    assign p1_ack      = p1_ack_q;
    assign p0_rdata    = p0_rdata_q;
    assign p1_rdata    = p1_rdata_q;
    assign mem_go      = mem_go_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;
    assign dbg_state_o = state_q;
endmodule
